// File: rtl/router_fsm_if.sv
// router_fsm_if: packet-control handshake between the router input side,
// router_sync / register block (master) and the router FSM (slave).
//   Inputs to FSM : pkt_valid, data_in[1:0], fifo_full, fifo_empty_0/1/2,
//                   soft_reset_0/1/2, parity_done, low_pkt_valid
//   Outputs of FSM: busy, detect_add, lfd_state, ld_state, laf_state,
//                   full_state, write_enb_reg, rst_int_reg
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: packet-level controller of the 1x3 router. Decodes the header
// destination, waits for the chosen FIFO to drain, then sequences header,
// payload and parity loads, stalling the source around FIFO-full events.
//   clk1  : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : router_fsm_if.slave (control inputs, Moore state strobes out)
module router_fsm (
    input  logic         clk1,
    input  logic         reset,
    router_fsm_if.slave  bus
);

    localparam logic [2:0] DA  = 3'd0;
    localparam logic [2:0] WTE = 3'd1;
    localparam logic [2:0] LFD = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] FFS = 3'd4;
    localparam logic [2:0] LAF = 3'd5;
    localparam logic [2:0] LP  = 3'd6;
    localparam logic [2:0] CPE = 3'd7;

    logic [2:0] state, nxt;
    logic [1:0] addr_q;
    logic       empty_in;   // empty flag of the port addressed by data_in
    logic       empty_sel;  // empty flag of the latched port
    logic       sr_sel;     // soft reset of the latched port

    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            2'd0:    empty_in = bus.fifo_empty_0;
            2'd1:    empty_in = bus.fifo_empty_1;
            2'd2:    empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    // addr_q can hold 2'b11 after an invalid header; that selects nothing.
    always_comb begin
        empty_sel = 1'b0;
        sr_sel    = 1'b0;
        case (addr_q)
            2'd0: begin empty_sel = bus.fifo_empty_0; sr_sel = bus.soft_reset_0; end
            2'd1: begin empty_sel = bus.fifo_empty_1; sr_sel = bus.soft_reset_1; end
            2'd2: begin empty_sel = bus.fifo_empty_2; sr_sel = bus.soft_reset_2; end
            default: begin empty_sel = 1'b0; sr_sel = 1'b0; end
        endcase
    end

    always_comb begin
        nxt = state;
        if (state != DA && sr_sel) begin
            nxt = DA;
        end else begin
            case (state)
                DA: begin
                    // data_in=3 is not a port: the header is dropped in place
                    if (bus.pkt_valid && bus.data_in != 2'b11)
                        nxt = empty_in ? LFD : WTE;
                end
                WTE: if (empty_sel) nxt = LFD;
                LFD: nxt = LD;
                LD: begin
                    if (bus.fifo_full)       nxt = FFS;
                    else if (!bus.pkt_valid) nxt = LP;
                end
                FFS: if (!bus.fifo_full) nxt = LAF;
                LAF: begin
                    if (bus.parity_done)        nxt = DA;
                    else if (bus.low_pkt_valid) nxt = LP;
                    else                        nxt = LD;
                end
                LP:  nxt = CPE;
                CPE: nxt = bus.fifo_full ? FFS : DA;
                default: nxt = DA;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state  <= DA;
            addr_q <= 2'b00;
        end else begin
            state <= nxt;
            if (state == DA && bus.pkt_valid)
                addr_q <= bus.data_in;
        end
    end

    // Moore decode: reset forces DA, so reset values appear without a clock.
    assign bus.detect_add    = (state == DA);
    assign bus.lfd_state     = (state == LFD);
    assign bus.ld_state      = (state == LD);
    assign bus.full_state    = (state == FFS);
    assign bus.laf_state     = (state == LAF);
    assign bus.rst_int_reg   = (state == CPE);
    assign bus.write_enb_reg = (state == LD) || (state == LAF) || (state == LP);
    assign bus.busy          = (state == LFD) || (state == WTE) || (state == FFS) ||
                               (state == LAF) || (state == LP)  || (state == CPE);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed bench for router_fsm. Each state is identified by
// its full output pattern {detect_add, lfd, ld, full, laf, rst_int, we, busy}.
module tb_router_fsm;

    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0010;
    localparam logic [7:0] E_FFS = 8'b0001_0001;
    localparam logic [7:0] E_LAF = 8'b0000_1011;
    localparam logic [7:0] E_CPE = 8'b0000_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    logic clk1 = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    router_fsm_if bus ();

    router_fsm dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    logic [7:0] outs;
    assign outs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                   bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

    // advance one clock; outputs are stable 1 time unit after the edge
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (outs !== E_DA) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%b want=%b", i, outs, E_DA);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (outs !== E_DA) begin
                bad++;
                $display("FAIL idle[%0d] got=%b want=%b", i, outs, E_DA);
            end
        end
    endtask

    task automatic test_port2_packet();
        logic [7:0] exp_s [0:6];
        int we_cnt, ri_cnt;
        exp_s = '{E_LFD, E_LD, E_LD, E_LD, E_LP, E_CPE, E_DA};
        we_cnt = 0;
        ri_cnt = 0;
        bus.fifo_empty_0 = 1'b0;
        bus.fifo_empty_2 = 1'b1;
        bus.data_in      = 2'b10;
        bus.pkt_valid    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (outs !== exp_s[i]) begin
                bad++;
                $display("FAIL port2_seq[%0d] got=%b want=%b", i, outs, exp_s[i]);
            end
            if (bus.write_enb_reg === 1'b1) we_cnt++;
            if (bus.rst_int_reg === 1'b1) ri_cnt++;
            if (i == 0) bus.data_in = 2'b00;   // payload bits are not an address
            if (i == 3) bus.pkt_valid = 1'b0;  // parity byte
        end
        total++;
        if (we_cnt != 4) begin
            bad++;
            $display("FAIL port2_we_count got=%0d want=4", we_cnt);
        end
        total++;
        if (ri_cnt != 1) begin
            bad++;
            $display("FAIL port2_rst_int_count got=%0d want=1", ri_cnt);
        end
        bus.fifo_empty_0 = 1'b1;
    endtask

    task automatic test_busy_dest();
        bus.fifo_empty_0 = 1'b0;
        bus.fifo_empty_2 = 1'b1;
        bus.data_in      = 2'b00;
        bus.pkt_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (outs !== E_WTE) begin
                bad++;
                $display("FAIL wte_hold[%0d] got=%b want=%b", i, outs, E_WTE);
            end
            // latched address must be used, not the live data_in (port 2 empty)
            bus.data_in = 2'b10;
        end
        bus.fifo_empty_0 = 1'b1;
        step();
        total++;
        if (outs !== E_LFD) begin
            bad++;
            $display("FAIL wte_to_lfd got=%b want=%b", outs, E_LFD);
        end
        step();
        bus.pkt_valid = 1'b0;
        step();
        step();
        step();
        total++;
        if (outs !== E_DA) begin
            bad++;
            $display("FAIL wte_pkt_end got=%b want=%b", outs, E_DA);
        end
    endtask

    task automatic test_full_payload();
        // stim bits: {fifo_full, pkt_valid, low_pkt_valid, parity_done}
        logic [3:0] stim  [0:13];
        logic [7:0] exp_s [0:13];
        stim  = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b1000,
                  4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp_s = '{E_LFD, E_LD, E_FFS, E_FFS, E_LAF, E_LD, E_FFS,
                  E_LAF, E_LP, E_CPE, E_FFS, E_LAF, E_DA, E_DA};
        bus.data_in      = 2'b01;
        bus.fifo_empty_1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            {bus.fifo_full, bus.pkt_valid, bus.low_pkt_valid, bus.parity_done} = stim[i];
            step();
            total++;
            if (outs !== exp_s[i]) begin
                bad++;
                $display("FAIL full_seq[%0d] got=%b want=%b", i, outs, exp_s[i]);
            end
        end
    endtask

    task automatic test_soft_reset();
        bus.data_in      = 2'b01;
        bus.fifo_empty_1 = 1'b1;
        bus.pkt_valid    = 1'b1;
        step();
        step();
        total++;
        if (outs !== E_LD) begin
            bad++;
            $display("FAIL sr_setup got=%b want=%b", outs, E_LD);
        end
        bus.soft_reset_0 = 1'b1;
        step();
        bus.soft_reset_0 = 1'b0;
        total++;
        if (outs !== E_LD) begin
            bad++;
            $display("FAIL sr_other_port0 got=%b want=%b", outs, E_LD);
        end
        bus.soft_reset_2 = 1'b1;
        step();
        bus.soft_reset_2 = 1'b0;
        total++;
        if (outs !== E_LD) begin
            bad++;
            $display("FAIL sr_other_port2 got=%b want=%b", outs, E_LD);
        end
        bus.soft_reset_1 = 1'b1;
        step();
        bus.soft_reset_1 = 1'b0;
        bus.pkt_valid    = 1'b0;
        total++;
        if (outs !== E_DA) begin
            bad++;
            $display("FAIL sr_selected got=%b want=%b", outs, E_DA);
        end
        step();
        total++;
        if (outs !== E_DA) begin
            bad++;
            $display("FAIL sr_after got=%b want=%b", outs, E_DA);
        end
    endtask

    task automatic test_invalid_and_async();
        bus.data_in   = 2'b11;
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (outs !== E_DA) begin
                bad++;
                $display("FAIL invalid_addr[%0d] got=%b want=%b", i, outs, E_DA);
            end
        end
        bus.data_in      = 2'b01;
        bus.fifo_empty_1 = 1'b1;
        step();
        step();
        total++;
        if (outs !== E_LD) begin
            bad++;
            $display("FAIL async_setup got=%b want=%b", outs, E_LD);
        end
        #2;
        reset = 1'b0;
        #1;   // well before the next rising edge
        total++;
        if (outs !== E_DA) begin
            bad++;
            $display("FAIL async_abort got=%b want=%b", outs, E_DA);
        end
        bus.pkt_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        total++;
        if (outs !== E_DA) begin
            bad++;
            $display("FAIL async_release got=%b want=%b", outs, E_DA);
        end
    endtask

    initial begin
        reset             = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'b00;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.soft_reset_0  = 1'b0;
        bus.soft_reset_1  = 1'b0;
        bus.soft_reset_2  = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        test_reset();
        test_port2_packet();
        test_busy_dest();
        test_full_payload();
        test_soft_reset();
        test_invalid_and_async();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router.
- Decodes the destination field of an incoming header and waits for the selected output FIFO to drain.
- Sequences header, payload and parity loading.
- Drives get_dest (detect_add) and write_enb_reg into router_sync, and the load/full/parity strobes into the register block.
- Sits between the input port and router_sync; one instance per router.

Parameters:
- None. Port count is fixed at 3; address field is data_in[1:0].

Ports:
- clk1  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- pkt_valid  input  1  input packet valid; high for header and payload, drops on the parity byte
- data_in  input  2  destination address bits of the header byte
- fifo_full  input  1  selected FIFO full (from router_sync)
- fifo_empty_0/1/2  input  1 each  output FIFO empty flags
- soft_reset_0/1/2  input  1 each  per-FIFO timeout soft reset (from router_sync)
- parity_done  input  1  parity byte already captured (from register block)
- low_pkt_valid  input  1  pkt_valid fell while the FIFO was full (from register block)
- busy  output  1  stall the source
- detect_add  output  1  header decode cycle; drives router_sync get_dest
- lfd_state  output  1  load first data (header)
- ld_state  output  1  load payload data
- laf_state  output  1  load-after-full
- full_state  output  1  FIFO full hold
- write_enb_reg  output  1  FIFO write enable to router_sync
- rst_int_reg  output  1  clear internal parity register

Behaviour:
- State register: 3 bits, 8 states: DA (decode address), WTE (wait till empty), LFD, LD, FFS (FIFO full), LAF, LP (load parity), CPE (check parity error).
- Reset: reset=0 forces state=DA and addr_q=2'b00 asynchronously. While reset is low: detect_add=1, all other outputs 0.
- addr_q is a 2-bit latch. It loads data_in when state=DA and pkt_valid=1, and holds otherwise.
- Transitions are evaluated each rising clk1 edge. The first matching rule wins.
  - Soft reset: soft_reset_<addr_q>=1 in any state other than DA → DA. This overrides all other rules. Soft resets on non-selected ports are ignored.
  - DA, with pkt_valid=1 and data_in=i (i in 0..2):
    - fifo_empty_i=1 → LFD
    - fifo_empty_i=0 → WTE
  - DA, with data_in=2'b11 or pkt_valid=0 → stay in DA. The invalid address is dropped and no write occurs.
  - WTE: fifo_empty_<addr_q>=1 → LFD; otherwise stay.
  - LFD → LD, unconditionally.
  - LD:
    - fifo_full=1 → FFS
    - else pkt_valid=0 → LP
    - else stay
    - fifo_full has priority when it coincides with pkt_valid falling.
  - FFS: fifo_full=0 → LAF; otherwise stay.
  - LAF:
    - parity_done=1 → DA
    - else low_pkt_valid=1 → LP
    - else → LD
  - LP → CPE, unconditionally.
  - CPE: fifo_full=1 → FFS; else → DA.
- Outputs are Moore, decoded from the state only, with no added latency:
  - detect_add=1 in DA only
  - lfd_state=1 in LFD only
  - ld_state=1 in LD only
  - full_state=1 in FFS only
  - laf_state=1 in LAF only
  - rst_int_reg=1 in CPE only
  - write_enb_reg=1 in LD, LAF and LP
  - busy=1 in LFD, WTE, FFS, LAF, LP and CPE; busy=0 in DA and LD
- Latency: the header is written in the cycle after decode (LFD). Payload writes every cycle in LD. Parity is written one cycle after pkt_valid falls.
- Reset mid-packet aborts immediately. The partial packet is left in the FIFO for router_sync to discard via soft reset.
- Unreachable state encodings recover to DA on the next edge.

Test Plan:
- Reset and idle: reset=0 for 2 cycles, then 1, with pkt_valid=0 → state DA, detect_add=1, busy=0, write_enb_reg=0 throughout.
- Header, 3-byte payload and parity to port 2 (data_in=2'b10, fifo_empty_2=1):
  - states DA→LFD→LD,LD,LD→LP→CPE→DA
  - write_enb_reg high for exactly 4 cycles (3 in LD, 1 in LP); rst_int_reg pulses 1 cycle.
- Busy destination: data_in=2'b00, fifo_empty_0=0 for 4 cycles then 1 → state WTE for 4 cycles with busy=1, then LFD.
- Full during payload:
  - fifo_full=1 in LD → FFS with full_state=1 and write_enb_reg=0.
  - fifo_full=0 → LAF.
  - LAF then goes to LD if low_pkt_valid=0 and parity_done=0; to LP if low_pkt_valid=1; to DA if parity_done=1.
- Soft reset abort: in LD with addr_q=1, pulse soft_reset_1 → DA next edge. A pulse on soft_reset_0 in the same situation leaves the state in LD.
- Invalid address and async reset: data_in=2'b11 with pkt_valid=1 → stays in DA, no write. Dropping reset to 0 mid-LD returns outputs to reset values without waiting for a clock edge.
